// File: rtl/layer_compositor.sv
// Two-stage pixel compositor: picks the highest-priority enabled sprite layer or a background,
// keeps syncs aligned with the RGB, and reports per-frame player collisions plus a frame counter.
module layer_compositor #(
   parameter int NUM_LAYERS  = 4,
   parameter int COLOR_W     = 8,
   parameter int COL_W       = 12,
   parameter int ROW_W       = 11,
   parameter int CHECKER_BIT = 7
) (
   input  logic                                  clock,
   input  logic                                  reset,
   input  logic                                  visible,
   input  logic                                  hsync,
   input  logic                                  vsync,
   input  logic [COL_W-1:0]                      display_col,
   input  logic [ROW_W-1:0]                      display_row,
   input  logic [NUM_LAYERS*(3*COLOR_W+1)-1:0]   layer_color,
   input  logic [NUM_LAYERS-1:0]                 layer_enable,
   input  logic [1:0]                            bg_mode,
   input  logic [3*COLOR_W-1:0]                  bg_color,
   output logic [COLOR_W-1:0]                    red_out,
   output logic [COLOR_W-1:0]                    green_out,
   output logic [COLOR_W-1:0]                    blue_out,
   output logic                                  hsync_out,
   output logic                                  vsync_out,
   output logic                                  blank_n_out,
   output logic [NUM_LAYERS-1:0]                 collision_flags,
   output logic                                  frame_pulse,
   output logic [15:0]                           frame_count
);

   localparam int LAYER_W = 3*COLOR_W + 1;
   localparam int RGB_W   = 3*COLOR_W;
   localparam int IDX_W   = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;

   // ---------------- stage 1: priority decode ----------------
   logic [NUM_LAYERS-1:0] valid_d;
   logic [IDX_W-1:0]      sel_d;
   logic                  sel_bg_d;

   always_comb begin
      // NOTE: every always_comb output is given a default first, so no path can infer a latch.
      valid_d  = '0;
      sel_d    = '0;
      sel_bg_d = 1'b1;
      // Scan from the lowest priority upward so the lowest valid index is the last one written.
      for (int i = NUM_LAYERS-1; i >= 0; i--) begin
         valid_d[i] = layer_color[i*LAYER_W] & layer_enable[i];
         if (valid_d[i]) begin
            sel_d    = IDX_W'(i);
            sel_bg_d = 1'b0;
         end
      end
   end

   logic                  vis_q, hs1_q, vs1_q, vs_prev_q, checker_q, sel_bg_q;
   logic [NUM_LAYERS-1:0] valid_q;
   logic [IDX_W-1:0]      sel_q;
   logic [1:0]            bg_mode_q;
   logic [RGB_W-1:0]      bg_color_q;
   logic [RGB_W-1:0]      colors_q [NUM_LAYERS];

   always_ff @(posedge clock) begin
      // NOTE: sequential state uses <= so every register samples the values from before the edge.
      if (reset) begin
         vis_q      <= 1'b0;
         hs1_q      <= 1'b1;
         vs1_q      <= 1'b1;
         vs_prev_q  <= 1'b1;
         checker_q  <= 1'b0;
         sel_bg_q   <= 1'b1;
         valid_q    <= '0;
         sel_q      <= '0;
         bg_mode_q  <= '0;
         bg_color_q <= '0;
         // NOTE: this array is a pipeline register, not a RAM, so it is cleared with everything else.
         for (int i = 0; i < NUM_LAYERS; i++) colors_q[i] <= '0;
      end else begin
         vis_q      <= visible;
         hs1_q      <= hsync;
         vs1_q      <= vsync;
         vs_prev_q  <= vs1_q;
         checker_q  <= display_row[CHECKER_BIT] ^ display_col[CHECKER_BIT];
         sel_bg_q   <= sel_bg_d;
         valid_q    <= valid_d;
         sel_q      <= sel_d;
         bg_mode_q  <= bg_mode;
         bg_color_q <= bg_color;
         for (int i = 0; i < NUM_LAYERS; i++) colors_q[i] <= layer_color[i*LAYER_W+1 +: RGB_W];
      end
   end

   // ---------------- stage 2: colour, syncs, frame bookkeeping ----------------
   logic [COLOR_W-1:0]    checker_ch;
   logic [RGB_W-1:0]      bg_rgb, rgb_d, rgb_q;
   logic [NUM_LAYERS-1:0] hits, acc_d, acc_q, flags_d, flags_q;
   logic [15:0]           frame_count_d, frame_count_q;
   logic                  boundary;
   logic                  hs2_q, vs2_q, blank_n_q, frame_pulse_q;

   assign checker_ch = {3'b011, {(COLOR_W-3){checker_q}}};
   assign boundary   = ~vs1_q & vs_prev_q;

   always_comb begin
      bg_rgb = '0;
      case (bg_mode_q)
         2'd0:    bg_rgb = {3{checker_ch}};
         2'd1:    bg_rgb = bg_color_q;
         default: bg_rgb = '0;
      endcase

      rgb_d = '0;
      if (vis_q) rgb_d = sel_bg_q ? bg_rgb : colors_q[sel_q];

      hits = '0;
      if (vis_q & valid_q[0]) hits = {valid_q[NUM_LAYERS-1:1], 1'b0};

      // Hits on the boundary cycle still belong to the frame that is closing.
      acc_d         = boundary ? '0 : (acc_q | hits);
      flags_d       = boundary ? (acc_q | hits) : flags_q;
      frame_count_d = frame_count_q + 16'(boundary);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         rgb_q         <= '0;
         hs2_q         <= 1'b1;
         vs2_q         <= 1'b1;
         blank_n_q     <= 1'b0;
         frame_pulse_q <= 1'b0;
         acc_q         <= '0;
         flags_q       <= '0;
         frame_count_q <= '0;
      end else begin
         rgb_q         <= rgb_d;
         hs2_q         <= hs1_q;
         vs2_q         <= vs1_q;
         blank_n_q     <= hs1_q & vs1_q;
         frame_pulse_q <= boundary;
         acc_q         <= acc_d;
         flags_q       <= flags_d;
         frame_count_q <= frame_count_d;
      end
   end

   assign {red_out, green_out, blue_out} = rgb_q;
   assign hsync_out       = hs2_q;
   assign vsync_out       = vs2_q;
   assign blank_n_out     = blank_n_q;
   assign frame_pulse     = frame_pulse_q;
   assign collision_flags = flags_q;
   assign frame_count     = frame_count_q;

endmodule

// File: tb/tb_layer_compositor.sv
// Self-checking bench for layer_compositor: directed scenarios plus randomized pixels,
// every output cycle compared against a frame-level reference model.
module tb_layer_compositor;

   localparam int NL    = 4;
   localparam int CW    = 8;
   localparam int COL_W = 12;
   localparam int ROW_W = 11;
   localparam int CB    = 7;
   localparam int LW    = 3*CW + 1;
   localparam int RGB_W = 3*CW;
   localparam int MAXC  = 4096;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic                 reset, visible, hsync, vsync;
   logic [COL_W-1:0]     display_col;
   logic [ROW_W-1:0]     display_row;
   logic [NL*LW-1:0]     layer_color;
   logic [NL-1:0]        layer_enable;
   logic [1:0]           bg_mode;
   logic [RGB_W-1:0]     bg_color;
   logic [CW-1:0]        red_out, green_out, blue_out;
   logic                 hsync_out, vsync_out, blank_n_out, frame_pulse;
   logic [NL-1:0]        collision_flags;
   logic [15:0]          frame_count;

   layer_compositor #(
      .NUM_LAYERS(NL), .COLOR_W(CW), .COL_W(COL_W), .ROW_W(ROW_W), .CHECKER_BIT(CB)
   ) dut (
      .clock(clock), .reset(reset), .visible(visible), .hsync(hsync), .vsync(vsync),
      .display_col(display_col), .display_row(display_row), .layer_color(layer_color),
      .layer_enable(layer_enable), .bg_mode(bg_mode), .bg_color(bg_color),
      .red_out(red_out), .green_out(green_out), .blue_out(blue_out),
      .hsync_out(hsync_out), .vsync_out(vsync_out), .blank_n_out(blank_n_out),
      .collision_flags(collision_flags), .frame_pulse(frame_pulse), .frame_count(frame_count)
   );

   typedef struct {
      logic             rst, vis, hs, vs;
      logic [COL_W-1:0] col;
      logic [ROW_W-1:0] row;
      logic [NL*LW-1:0] lc;
      logic [NL-1:0]    en;
      logic [1:0]       bm;
      logic [RGB_W-1:0] bgc;
   } pix_t;

   pix_t        hist [MAXC];
   pix_t        cur;
   int          k = 0;
   int          errors = 0;
   int          checks = 0;
   logic [NL-1:0] m_acc, m_flags;
   logic [15:0] m_cnt;
   bit          mon = 1'b0;
   int          hs_low, hs_first, s;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, k);
      end
   endtask

   function automatic logic vld(input pix_t p, input int i);
      return p.lc[i*LW] & p.en[i];
   endfunction

   function automatic logic [RGB_W-1:0] ref_rgb(input pix_t p);
      logic [CW-1:0] ch;
      if (!p.vis) return '0;
      for (int i = 0; i < NL; i++)
         if (vld(p, i)) return p.lc[i*LW+1 +: RGB_W];
      if (p.bm == 2'd0) begin
         ch = (p.row[CB] ^ p.col[CB]) ? 8'h7F : 8'h60;
         return {ch, ch, ch};
      end
      if (p.bm == 2'd1) return p.bgc;
      return '0;
   endfunction

   function automatic logic [NL-1:0] ref_hits(input pix_t p);
      logic [NL-1:0] h;
      h = '0;
      if (p.vis && vld(p, 0))
         for (int i = 1; i < NL; i++) h[i] = vld(p, i);
      return h;
   endfunction

   // Output after edge k reflects the input sampled at edge k-1.
   task automatic model_and_check();
      pix_t p;
      logic [RGB_W-1:0] e_rgb;
      logic e_hs, e_vs, e_bl, e_pl, prev, bnd;
      logic [NL-1:0] h;
      if (hist[k].rst) begin
         m_acc = '0; m_flags = '0; m_cnt = '0;
         e_rgb = '0; e_hs = 1'b1; e_vs = 1'b1; e_bl = 1'b0; e_pl = 1'b0;
      end else if (k == 0 || hist[k-1].rst) begin
         e_rgb = '0; e_hs = 1'b1; e_vs = 1'b1; e_bl = 1'b1; e_pl = 1'b0;
      end else begin
         p    = hist[k-1];
         prev = (k < 2 || hist[k-2].rst) ? 1'b1 : hist[k-2].vs;
         bnd  = !p.vs && prev;
         h    = ref_hits(p);
         if (bnd) begin
            m_flags = m_acc | h;
            m_acc   = '0;
            m_cnt   = m_cnt + 16'd1;
         end else begin
            m_acc = m_acc | h;
         end
         e_rgb = ref_rgb(p); e_hs = p.hs; e_vs = p.vs; e_bl = p.hs & p.vs; e_pl = bnd;
      end
      check("rgb",   {red_out, green_out, blue_out}, e_rgb);
      check("hsync", hsync_out, e_hs);
      check("vsync", vsync_out, e_vs);
      check("blank", blank_n_out, e_bl);
      check("pulse", frame_pulse, e_pl);
      check("flags", collision_flags, m_flags);
      check("count", frame_count, m_cnt);
   endtask

   task automatic step();
      @(negedge clock);
      reset = cur.rst; visible = cur.vis; hsync = cur.hs; vsync = cur.vs;
      display_col = cur.col; display_row = cur.row; layer_color = cur.lc;
      layer_enable = cur.en; bg_mode = cur.bm; bg_color = cur.bgc;
      if (k >= MAXC) begin
         $display("FAIL history: cycle %0d exceeds limit %0d", k, MAXC);
         $fatal(1);
      end
      hist[k] = cur;
      @(posedge clock);
      #1;
      model_and_check();
      if (mon && !hsync_out) begin
         if (hs_low == 0) hs_first = k;
         hs_low++;
      end
      k++;
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   function automatic pix_t idle();
      pix_t p;
      p.rst = 1'b0; p.vis = 1'b1; p.hs = 1'b1; p.vs = 1'b1;
      p.col = '0; p.row = '0; p.lc = '0; p.en = '1; p.bm = 2'd2; p.bgc = '0;
      return p;
   endfunction

   function automatic logic [NL*LW-1:0] set_layer(input logic [NL*LW-1:0] bus, input int idx,
                                                  input logic [RGB_W-1:0] rgb, input logic v);
      bus[idx*LW +: LW] = {rgb, v};
      return bus;
   endfunction

   initial begin
      m_acc = '0; m_flags = '0; m_cnt = '0;
      cur = idle(); cur.rst = 1'b1;
      run(3);
      check("rst_rgb",   {red_out, green_out, blue_out}, 24'h0);
      check("rst_blank", blank_n_out, 1'b0);
      check("rst_sync",  {hsync_out, vsync_out}, 2'b11);
      cur.rst = 1'b0;

      // priority and enable masking
      cur.lc = set_layer(set_layer('0, 0, 24'hFF0000, 1'b1), 2, 24'h00FF00, 1'b1);
      run(3);
      check("prio_l0", {red_out, green_out, blue_out}, 24'hFF0000);
      cur.en = 4'b1110;
      run(3);
      check("prio_l2", {red_out, green_out, blue_out}, 24'h00FF00);

      // backgrounds
      cur.lc = '0; cur.en = '1; cur.bm = 2'd0; cur.row = 11'h080; cur.col = '0;
      run(3);
      check("bg_chk_hi", {red_out, green_out, blue_out}, 24'h7F7F7F);
      cur.col = 12'h080;
      run(3);
      check("bg_chk_lo", {red_out, green_out, blue_out}, 24'h606060);
      cur.bm = 2'd1; cur.bgc = 24'h123456;
      run(3);
      check("bg_solid", {red_out, green_out, blue_out}, 24'h123456);
      cur.bm = 2'd2;
      run(3);
      check("bg_black", {red_out, green_out, blue_out}, 24'h0);

      // blanking, then a 112-cycle hsync pulse
      cur.vis = 1'b0; cur.lc = set_layer('0, 1, 24'hABCDEF, 1'b1);
      run(3);
      check("blank_rgb", {red_out, green_out, blue_out}, 24'h0);
      cur.vis = 1'b1; mon = 1'b1; hs_low = 0; hs_first = -1; s = k;
      cur.hs = 1'b0;
      run(112);
      cur.hs = 1'b1;
      run(6);
      mon = 1'b0;
      check("hs_width", hs_low, 112);
      check("hs_start", hs_first, s + 1);

      // one-pixel overlap of layer 0 and layer 3
      cur = idle(); cur.rst = 1'b1;
      run(2);
      cur.rst = 1'b0;
      run(4);
      cur.lc = set_layer('0, 1, 24'h0000FF, 1'b1);
      run(3);
      cur.lc = set_layer(set_layer('0, 0, 24'h111111, 1'b1), 3, 24'h333333, 1'b1);
      run(1);
      cur.lc = set_layer('0, 0, 24'h111111, 1'b1);
      run(2);
      cur.lc = '0;
      run(2);
      cur.vs = 1'b0;
      run(2);
      check("col_pulse", frame_pulse, 1'b1);
      check("col_flags", collision_flags, 4'b1000);
      check("col_count", frame_count, 16'd1);
      run(1);
      check("col_pulse_end", frame_pulse, 1'b0);
      run(2);
      // layer 1 overlaps but is disabled, so no hit
      cur.vs = 1'b1; cur.en = 4'b1101;
      cur.lc = set_layer(set_layer('0, 0, 24'h111111, 1'b1), 1, 24'h222222, 1'b1);
      run(10);
      cur.vs = 1'b0;
      run(2);
      check("nocol_flags", collision_flags, 4'b0000);
      check("nocol_count", frame_count, 16'd2);

      // reset in the middle of a frame that already saw a hit
      cur.vs = 1'b1; cur.en = '1;
      run(3);
      run(2);
      cur.lc = '0; cur.rst = 1'b1;
      run(1);
      check("mid_rst_rgb",   {red_out, green_out, blue_out}, 24'h0);
      check("mid_rst_blank", blank_n_out, 1'b0);
      check("mid_rst_count", frame_count, 16'd0);
      check("mid_rst_flags", collision_flags, 4'b0000);
      cur.rst = 1'b0;
      run(5);
      cur.vs = 1'b0;
      run(2);
      check("post_rst_flags", collision_flags, 4'b0000);
      check("post_rst_count", frame_count, 16'd1);

      // counter wrap
      cur.vs = 1'b1;
      run(4);
      force dut.frame_count_q = 16'hFFFF;
      m_cnt = 16'hFFFF;
      run(2);
      release dut.frame_count_q;
      run(2);
      check("pre_wrap", frame_count, 16'hFFFF);
      cur.vs = 1'b0;
      run(2);
      check("wrap_count", frame_count, 16'h0000);
      check("wrap_pulse", frame_pulse, 1'b1);

      // randomized traffic with short frames and lines
      for (int n = 0; n < 2400; n++) begin
         cur.rst = ($urandom_range(0, 499) == 0);
         cur.vs  = ((n % 64) < 3) ? 1'b0 : 1'b1;
         cur.hs  = ((n % 16) < 2) ? 1'b0 : 1'b1;
         cur.vis = ($urandom_range(0, 9) != 0);
         cur.col = COL_W'($urandom);
         cur.row = ROW_W'($urandom);
         for (int i = 0; i < NL; i++)
            cur.lc[i*LW +: LW] = {RGB_W'($urandom), ($urandom_range(0, 2) == 0)};
         cur.en  = NL'($urandom);
         cur.bm  = 2'($urandom);
         cur.bgc = RGB_W'($urandom);
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/layer_compositor.md
# layer_compositor

Parametrised pixel compositor that replaces the fixed ship/bullet/background mux in the game top level. It takes NUM_LAYERS sprite colour buses plus the VGA timing signals and selects the highest-priority visible layer per pixel, or a configurable background. It outputs registered RGB with sync and blank delayed to the same latency. It also reports per-frame collisions between layer 0 (player) and every other layer, and counts frames.

## Interface

- NUM_LAYERS, 4, number of sprite layers (2..8); index 0 = highest priority = player layer
- COLOR_W, 8, bits per colour channel (>=4)
- COL_W, 12, display_col width
- ROW_W, 11, display_row width
- CHECKER_BIT, 7, row/col bit driving the checkerboard background

- clock  in  1  pixel clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- visible  in  1  pixel is in the active field
- hsync  in  1  horizontal sync, active-low
- vsync  in  1  vertical sync, active-low
- display_col  in  COL_W  current pixel column
- display_row  in  ROW_W  current pixel row
- layer_color  in  NUM_LAYERS*(3*COLOR_W+1)  per layer {R,G,B,valid}; layer i occupies bits [(i+1)*(3*COLOR_W+1)-1 : i*(3*COLOR_W+1)], valid = LSB
- layer_enable  in  NUM_LAYERS  per-layer mask; a disabled layer is treated as not valid
- bg_mode  in  2  0 checker, 1 solid bg_color, 2 and 3 black
- bg_color  in  3*COLOR_W  {R,G,B} for solid background
- red_out, green_out, blue_out  out  COLOR_W each  composited pixel
- hsync_out, vsync_out  out  1  syncs delayed to match RGB
- blank_n_out  out  1  hsync_out & vsync_out
- collision_flags  out  NUM_LAYERS  bit i set if layer 0 overlapped layer i during the previous frame; bit 0 always 0
- frame_pulse  out  1  one-cycle strobe at each frame boundary
- frame_count  out  16  frames since reset, wraps

## Operation

- Effective valid: v[i] = layer_color valid bit of layer i & layer_enable[i].
- Priority: the lowest i with v[i]=1 supplies RGB. If no layer is valid, the background supplies RGB.
- Checker background: each channel = {3'b011, (COLOR_W-3) copies of display_row[CHECKER_BIT] ^ display_col[CHECKER_BIT]}.
- When visible=0, RGB is 0 regardless of layers or background.
- Pipeline stage 1 registers visible, syncs, v[], the selected layer index (or "bg"), and the checker bit. Stage 2 registers the final RGB and the delayed syncs.
- Collision accumulator collision_acc (NUM_LAYERS bits, bit 0 tied 0):
  - Evaluated on stage-1 signals.
  - Bit i is set when visible & v[0] & v[i].
- Frame boundary: stage-1 vsync = 0 while the previous stage-1 vsync = 1, i.e. the falling edge. On that cycle:
  - collision_flags <= collision_acc | the same cycle's hits
  - collision_acc <= 0
  - frame_count <= frame_count + 1, wrapping 0xFFFF -> 0
  - frame_pulse = 1 for exactly this cycle
- The previous-vsync register resets to 1, so no spurious boundary occurs after reset.

## Timing

- Latency: inputs at cycle n appear on RGB/hsync_out/vsync_out/blank_n_out at cycle n+2, and all four stay aligned.
- frame_pulse, collision_flags and frame_count update 2 cycles after the input vsync falling edge, coincident with the first vsync_out=0 cycle.
- Reset values:
  - RGB = 0, blank_n_out = 0, frame_pulse = 0
  - hsync_out = 1, vsync_out = 1
  - collision_flags = 0, collision_acc = 0, frame_count = 0
  - Pipeline registers cleared, with syncs at 1 and visible at 0.
- Reset asserted mid-frame clears everything on the next edge. The first boundary after deassertion reports only hits seen since deassertion.
- layer_enable and bg_mode are sampled every cycle with no shadowing, so a change takes effect after 2 cycles.

## Test plan

- Priority: layers 0 and 2 both valid with colours 0xFF0000 and 0x00FF00, visible=1 -> RGB = FF,00,00 two cycles later. Then disable layer 0 via layer_enable -> 00,FF,00.
- Background: no layer valid, bg_mode=0.
  - row bit7=1, col bit7=0 -> each channel 0x7F.
  - row bit7 = col bit7 -> 0x60.
  - bg_mode=1 with bg_color=0x123456 -> 12,34,56.
  - bg_mode=2 -> 0.
- Blanking and latency: visible=0 with a valid layer -> RGB 0. Drive an hsync pulse of 112 cycles -> hsync_out low for 112 cycles, starting exactly 2 cycles later. blank_n_out = hsync_out & vsync_out.
- Collision: during one frame, overlap layer 0 with layer 3 for one pixel. At the next vsync falling edge -> frame_pulse high for 1 cycle, collision_flags=4'b1000, frame_count=1. Following frame has no overlap -> flags 0, count 2.
- Reset mid-frame after a collision -> all outputs at reset values. Next boundary -> flags 0, count 1. Force frame_count to 0xFFFF -> the next boundary gives 0.
